// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory fill arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2,
        WRITE  = 2'd3
    } arb_state_t;

    localparam int          WORDS       = 8;
    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
    localparam int          WORD_STRIDE = 2;

endpackage
`default_nettype wire

// File: rtl/mem_fill_arbiter_word_counter.sv
`default_nettype none
// ============================================================================
// Module      : word_counter
// Description : Up-counter with clear/enable and a sticky terminal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module word_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             full
);

    logic [WIDTH-1:0] r_count;
    logic             r_full;

    // full stays set after the count wraps past all-ones, so 2**WIDTH
    // events are distinguishable from zero events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
            if (r_count == '1) begin
                r_full <= 1'b1;
            end
        end
    end

    assign count = r_count;
    assign full  = r_full;

endmodule
`default_nettype wire

// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_fill_arbiter
// Description : Arbitrates I-fills, D-fills and D write-throughs onto one
//               pipelined memory port and streams fill words back.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fill_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int WORDS   = 8,
    parameter int AW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic          d_wr,
    input  logic [AW-1:0] d_wdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_enable,
    output logic          mem_wr,
    output logic [AW-1:0] mem_data_in,
    input  logic [AW-1:0] mem_data_out,
    input  logic          mem_data_valid,
    output logic [AW-1:0] fill_data,
    output logic [2:0]    fill_word,
    output logic          fill_we_i,
    output logic          fill_we_d,
    output logic          i_done,
    output logic          d_done,
    output logic          wr_done,
    output logic          i_busy,
    output logic          d_busy
);

    import mem_arb_pkg::*;

    localparam int CW = $clog2(WORDS);
    localparam int OW = $clog2(WORDS + 1);

    if (MEM_LAT < 1) begin : g_lat_check
        $error("mem_fill_arbiter: MEM_LAT must be at least 1");
    end

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [AW-1:0] r_base;
    logic [OW-1:0] r_outstanding;
    logic [CW-1:0] w_issue_cnt;
    logic [CW-1:0] w_ret_cnt;
    logic          w_issue_full;
    logic          w_ret_full;
    logic          w_in_fill;
    logic          w_issue;
    logic          w_accept;
    logic          w_done;
    logic          w_cnt_clr;
    logic          w_enter_fill;

    assign w_in_fill    = (r_state == FILL_I) || (r_state == FILL_D);
    assign w_issue      = w_in_fill && !w_issue_full;
    // A valid with nothing outstanding is stray or from before a reset.
    assign w_accept     = w_in_fill && mem_data_valid && (r_outstanding != '0);
    assign w_done       = w_in_fill && w_ret_full;
    assign w_cnt_clr    = !w_in_fill || w_done;
    assign w_enter_fill = w_cnt_clr && ((w_next == FILL_I) || (w_next == FILL_D));

    word_counter #(.WIDTH(CW)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cnt_clr),
        .en    (w_issue),
        .count (w_issue_cnt),
        .full  (w_issue_full)
    );

    word_counter #(.WIDTH(CW)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cnt_clr),
        .en    (w_accept),
        .count (w_ret_cnt),
        .full  (w_ret_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_base        <= '0;
            r_outstanding <= '0;
        end else begin
            r_state <= w_next;
            if (w_enter_fill) begin
                r_base <= ((w_next == FILL_I) ? i_addr : d_addr) & AW'(BLOCK_MASK);
            end
            if (w_cnt_clr) begin
                r_outstanding <= '0;
            end else begin
                r_outstanding <= r_outstanding + OW'(w_issue) - OW'(w_accept);
            end
        end
    end

    // The done cycle re-arbitrates directly, skipping the requester that is
    // just finishing since it still holds its request during this cycle.
    always_comb begin
        w_next      = r_state;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        fill_data   = '0;
        fill_word   = '0;
        fill_we_i   = 1'b0;
        fill_we_d   = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        wr_done     = 1'b0;
        i_busy      = (r_state == FILL_I);
        d_busy      = (r_state == FILL_D) || (r_state == WRITE);

        unique case (r_state)
            IDLE: begin
                if (i_req)      w_next = FILL_I;
                else if (d_req) w_next = FILL_D;
                else if (d_wr)  w_next = WRITE;
            end
            FILL_I: begin
                if (w_done) begin
                    if (d_req)     w_next = FILL_D;
                    else if (d_wr) w_next = WRITE;
                    else           w_next = IDLE;
                end
            end
            FILL_D: begin
                if (w_done) begin
                    if (i_req)     w_next = FILL_I;
                    else if (d_wr) w_next = WRITE;
                    else           w_next = IDLE;
                end
            end
            WRITE: begin
                w_next = IDLE;
            end
        endcase

        if (w_issue) begin
            mem_enable = 1'b1;
            mem_addr   = r_base + AW'(w_issue_cnt) * AW'(WORD_STRIDE);
        end else if (r_state == WRITE) begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = d_addr;
            mem_data_in = d_wdata;
            wr_done     = 1'b1;
        end

        if (w_accept) begin
            fill_data = mem_data_out;
            fill_word = 3'(w_ret_cnt);
            fill_we_i = (r_state == FILL_I);
            fill_we_d = (r_state == FILL_D);
        end

        i_done = w_done && (r_state == FILL_I);
        d_done = w_done && (r_state == FILL_D);
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_fill_arbiter
// Description : Randomised self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_fill_arbiter;

    localparam int AW      = 16;
    localparam int WORDS   = 8;
    localparam int MEM_LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_wr;
    logic [AW-1:0] i_addr, d_addr, d_wdata;
    logic [AW-1:0] mem_addr, mem_data_in, mem_data_out, fill_data;
    logic          mem_enable, mem_wr, mem_data_valid;
    logic [2:0]    fill_word;
    logic          fill_we_i, fill_we_d, i_done, d_done, wr_done, i_busy, d_busy;

    mem_fill_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
        .i_done(i_done), .d_done(d_done), .wr_done(wr_done),
        .i_busy(i_busy), .d_busy(d_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // ---------------- memory environment ----------------
    logic [15:0] q_addr[$];
    int          q_due[$];
    bit          gap_mode    = 0;
    bit          stray_en    = 0;
    bit          stray_force = 0;
    int          last_valid  = -100;

    // ---------------- reference model state ----------------
    int          m_mode = 0;   // 0 idle, 1 I-fill, 2 D-fill, 3 write
    int          m_iss = 0, m_ret = 0, m_out = 0;
    logic [15:0] m_base = '0;

    // ---------------- observed event log ----------------
    int cnt_we_i, cnt_we_d, cnt_done_i, cnt_done_d, cnt_wr;
    int first_we_i, last_we_d, done_cyc_i, done_cyc_d, wr_cyc, first_dbusy;

    task automatic clear_log();
        cnt_we_i = 0; cnt_we_d = 0; cnt_done_i = 0; cnt_done_d = 0; cnt_wr = 0;
        first_we_i = -1; last_we_d = -1; done_cyc_i = -1; done_cyc_d = -1;
        wr_cyc = -1; first_dbusy = -1;
    endtask

    // Memory responds MEM_LAT cycles after a read issue, optionally spaced out.
    initial begin
        mem_data_valid = 1'b0;
        mem_data_out   = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (q_due.size() > 0 && q_due[0] <= cyc &&
                (!gap_mode || cyc - last_valid >= 3)) begin
                mem_data_valid = 1'b1;
                mem_data_out   = mem_word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
                last_valid = cyc;
            end else if (q_due.size() == 0 && m_out == 0 &&
                         (stray_force || (stray_en && $urandom_range(0, 3) == 0))) begin
                mem_data_valid = 1'b1;
                mem_data_out   = 16'($urandom);
            end else begin
                mem_data_valid = 1'b0;
                mem_data_out   = 16'($urandom);
            end
        end
    end

    task automatic model_start(input int mode, input logic [15:0] a);
        m_mode = mode;
        m_base = a & 16'hFFF0;
        m_iss  = 0;
        m_ret  = 0;
        m_out  = 0;
    endtask

    task automatic model_arbitrate(input bit allow_i, input bit allow_d);
        if (allow_i && i_req)      model_start(1, i_addr);
        else if (allow_d && d_req) model_start(2, d_addr);
        else if (d_wr)             m_mode = 3;
        else                       m_mode = 0;
    endtask

    // Compare every cycle against the model, then log and advance the model.
    initial begin
        logic [33:0] e_bus;
        logic [20:0] e_fill;
        logic [4:0]  e_stat;
        bit          fill, issue, acc, done;
        forever begin
            @(negedge clk);
            e_bus = '0; e_fill = '0; e_stat = '0;
            fill  = (m_mode == 1 || m_mode == 2);
            issue = 0; acc = 0; done = 0;
            if (rst_n === 1'b1) begin
                if (fill) begin
                    issue = (m_iss < WORDS);
                    acc   = mem_data_valid && (m_out > 0);
                    done  = (m_ret == WORDS);
                    if (issue) e_bus = {2'b10, 16'(m_base + 2 * m_iss), 16'h0000};
                    if (acc)   e_fill = {m_mode == 1, m_mode == 2, 3'(m_ret),
                                         mem_word(16'(m_base + 2 * m_ret))};
                    e_stat = {m_mode == 1 && done, m_mode == 2 && done, 1'b0,
                              m_mode == 1, m_mode == 2};
                end else if (m_mode == 3) begin
                    e_bus  = {2'b11, d_addr, d_wdata};
                    e_stat = 5'b00101;
                end
            end
            check("mem_bus", {mem_enable, mem_wr, mem_addr, mem_data_in}, e_bus);
            check("fill", {fill_we_i, fill_we_d, fill_word, fill_data}, e_fill);
            check("status", {i_done, d_done, wr_done, i_busy, d_busy}, e_stat);

            if (mem_enable && !mem_wr) begin
                q_addr.push_back(mem_addr);
                q_due.push_back(cyc + MEM_LAT);
            end
            if (fill_we_i) begin cnt_we_i++; if (first_we_i < 0) first_we_i = cyc; end
            if (fill_we_d) begin cnt_we_d++; last_we_d = cyc; end
            if (i_done)    begin cnt_done_i++; done_cyc_i = cyc; end
            if (d_done)    begin cnt_done_d++; done_cyc_d = cyc; end
            if (wr_done)   begin cnt_wr++; wr_cyc = cyc; end
            if (d_busy && first_dbusy < 0) first_dbusy = cyc;

            if (rst_n !== 1'b1) begin
                m_mode = 0; m_iss = 0; m_ret = 0; m_out = 0;
            end else if (m_mode == 0) begin
                model_arbitrate(1, 1);
            end else if (m_mode == 3) begin
                m_mode = 0;
            end else if (done) begin
                model_arbitrate(m_mode == 2, m_mode == 1);
            end else begin
                m_iss += int'(issue);
                m_ret += int'(acc);
                m_out += int'(issue) - int'(acc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_i_done(input int start);
        int k = 0;
        while (cnt_done_i == start && k < 300) begin step(); k++; end
        if (cnt_done_i == start) check("i_done_timeout", 1, 0);
    endtask

    task automatic wait_d_done(input int start);
        int k = 0;
        while (cnt_done_d == start && k < 300) begin step(); k++; end
        if (cnt_done_d == start) check("d_done_timeout", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        rst_n = 1'b0; i_req = 0; d_req = 0; d_wr = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        clear_log();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Single I-fill with exact timing
        clear_log();
        i_req = 1; i_addr = 16'h1236; c0 = cyc;
        wait_i_done(0);
        i_req = 0;
        check("i_done_cycle", done_cyc_i - c0, 13);
        check("i_first_word_cycle", first_we_i - c0, 5);
        check("i_word_count", cnt_we_i, 8);
        check("i_no_we_d", cnt_we_d, 0);
        check("i_done_pulses", cnt_done_i, 1);
        repeat (3) step();

        // I and D together: D starts right after i_done
        clear_log();
        i_req = 1; i_addr = 16'($urandom); d_req = 1; d_addr = 16'h4008;
        wait_i_done(0);
        i_req = 0;
        wait_d_done(0);
        d_req = 0;
        check("d_after_i", first_dbusy - done_cyc_i, 1);
        check("d_word_count", cnt_we_d, 8);
        check("d_done_pulses", cnt_done_d, 1);
        repeat (3) step();

        // Write-through
        clear_log();
        d_wr = 1; d_addr = 16'h0020; d_wdata = 16'hBEEF; c0 = cyc;
        step();
        step();
        d_wr = 0;
        check("wr_cycle", wr_cyc - c0, 1);
        check("wr_pulses", cnt_wr, 1);
        repeat (3) step();

        // Spaced-out memory responses
        clear_log();
        gap_mode = 1;
        d_req = 1; d_addr = 16'($urandom);
        wait_d_done(0);
        d_req = 0;
        check("gap_done_after_last", done_cyc_d - last_we_d, 1);
        check("gap_word_count", cnt_we_d, 8);
        gap_mode = 0;
        repeat (3) step();

        // Reset in the middle of an I-fill, then a D-fill
        clear_log();
        i_req = 1; i_addr = 16'($urandom); c0 = cyc;
        while (cyc < c0 + 6) step();
        rst_n = 0; i_req = 0;
        repeat (2) step();
        rst_n = 1; d_req = 1; d_addr = 16'($urandom);
        wait_d_done(0);
        d_req = 0;
        check("rst_d_words", cnt_we_d, 8);
        check("rst_no_i_done", cnt_done_i, 0);
        repeat (3) step();

        // Stray valids while idle
        clear_log();
        stray_force = 1;
        repeat (5) step();
        stray_force = 0;
        step();
        check("stray_we", cnt_we_i + cnt_we_d, 0);
        check("stray_done", cnt_done_i + cnt_done_d + cnt_wr, 0);

        // Random concurrent traffic from both caches
        stray_en = 1;
        fork
            begin
                for (int t = 0; t < 15; t++) begin
                    int st;
                    repeat ($urandom_range(1, 6)) step();
                    st = cnt_done_i;
                    i_req = 1; i_addr = 16'($urandom);
                    wait_i_done(st);
                    i_req = 0;
                end
            end
            begin
                for (int t = 0; t < 20; t++) begin
                    int kind, st_d, st_w, k;
                    repeat ($urandom_range(1, 5)) step();
                    kind = $urandom_range(0, 2);
                    gap_mode = ($urandom_range(0, 2) == 0);
                    d_addr = 16'($urandom); d_wdata = 16'($urandom);
                    st_d = cnt_done_d; st_w = cnt_wr;
                    d_req = (kind != 1);
                    d_wr  = (kind != 0);
                    k = 0;
                    while ((d_req || d_wr) && k < 400) begin
                        step();
                        k++;
                        if (cnt_done_d != st_d) d_req = 0;
                        if (cnt_wr != st_w)     d_wr = 0;
                    end
                    if (d_req || d_wr) begin
                        check("d_side_timeout", 1, 0);
                        d_req = 0; d_wr = 0;
                    end
                end
            end
        join
        stray_en = 0;
        gap_mode = 0;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Sits between the instruction cache, the data cache and the single shared 4-cycle main memory.
- Arbitrates I-cache block fills, D-cache block fills and D-cache single-word write-throughs onto one memory port.
- Streams returned fill words, each tagged with its word index, back to the requesting cache.
- Instruction fills have priority, because every instruction needs fetching but only some instructions touch memory.

Parameters:
- MEM_LAT, 4: memory read latency in cycles, from enable to data_valid; the memory is pipelined and accepts one request per cycle.
- WORDS, 8: 16-bit words per cache block.
- AW, 16: address and data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  I-cache fill request (level, held until i_done).
- i_addr  in  AW  I-cache miss address.
- d_req  in  1  D-cache fill request (level, held until d_done).
- d_addr  in  AW  D-cache miss or write address.
- d_wr  in  1  D-cache write-through request (level, held until wr_done).
- d_wdata  in  AW  write-through data.
- mem_addr  out  AW  memory address.
- mem_enable  out  1  memory request strobe.
- mem_wr  out  1  memory write strobe.
- mem_data_in  out  AW  memory write data.
- mem_data_out  in  AW  memory read data.
- mem_data_valid  in  1  memory read data valid.
- fill_data  out  AW  word to write into the cache (equals mem_data_out).
- fill_word  out  3  word index of fill_data within the block.
- fill_we_i  out  1  I-cache data-array write enable.
- fill_we_d  out  1  D-cache data-array write enable.
- i_done  out  1  one-cycle pulse: I-fill complete; the cache writes its tag array on this pulse.
- d_done  out  1  one-cycle pulse: D-fill complete.
- wr_done  out  1  one-cycle pulse: write-through issued.
- i_busy  out  1  high while state is FILL_I.
- d_busy  out  1  high while state is FILL_D or WRITE.

Behaviour:
- States: IDLE, FILL_I, FILL_D, WRITE. State, counters and the latched base address are flops. Reset value of every registered output is 0 and the state resets to IDLE.
- IDLE arbitration, sampled at the rising edge:
  - i_req goes to FILL_I;
  - else d_req goes to FILL_D;
  - else d_wr goes to WRITE;
  - else stay in IDLE.
- On entering a fill state: latch base = addr & 16'hFFF0, and clear issue_cnt, ret_cnt and outstanding.
- Issue phase, while issue_cnt < WORDS:
  - mem_enable = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt;
  - issue_cnt increments every cycle, so all 8 reads issue on 8 consecutive cycles;
  - outstanding increments on each issue.
- Return phase, for each mem_data_valid while outstanding > 0:
  - fill_we_x = 1 for the owning cache, fill_word = ret_cnt, fill_data = mem_data_out;
  - ret_cnt increments and outstanding decrements.
- Completion: when ret_cnt reaches WORDS, the next cycle pulses i_done or d_done for exactly one cycle and the state returns to IDLE. The next arbitration happens at the end of the done cycle.
- Fill latency with MEM_LAT = 4:
  - request sampled at the end of cycle 0;
  - issues in cycles 1–8;
  - fill words in cycles 5–12;
  - done in cycle 13.
- WRITE, one cycle: mem_enable = 1, mem_wr = 1, mem_addr = d_addr, mem_data_in = d_wdata, wr_done = 1. The next state is IDLE.
- Simultaneous events:
  - i_req and d_req together: the I-fill is served first and the D-fill next, with no idle cycle beyond the done cycle.
  - d_req and d_wr together: the fill is served first; d_wr is served afterwards if it is still held.
- Requests are not preempted. Deasserting a request mid-fill is ignored and the fill completes.
- mem_data_valid while outstanding == 0 is ignored, which covers stray valids in IDLE and stale responses after reset.
- mem_enable is never asserted outside the issue phase or WRITE.
- Reset mid-operation asynchronously clears everything to IDLE. In-flight memory responses are discarded by the outstanding == 0 rule.
- Combinational outputs are 0 in IDLE: mem_addr, mem_data_in, fill_data and fill_word are 0 whenever their strobes are low.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, FILL_I, FILL_D, WRITE};
  - WORDS;
  - BLOCK_MASK = 16'hFFF0;
  - WORD_STRIDE = 2.
- Sub-module word_counter (3-bit up-counter with clear, enable and terminal-count outputs), instantiated twice: issue_cnt and ret_cnt.
- The outstanding counter is inline.

Test Plan:
- i_req = 1, i_addr = 16'h1236, memory latency 4 → mem_addr = 1230, 1232, …, 123E in cycles 1–8; fill_we_i with fill_word 0–7 in cycles 5–12; i_done only in cycle 13; fill_we_d never asserted.
- i_req and d_req asserted together in cycle 0, d_addr = 16'h4008 → the I-fill completes first; FILL_D starts the cycle after i_done; mem_addr 4000–400E; d_done pulses once.
- d_wr = 1, d_addr = 16'h0020, d_wdata = 16'hBEEF → in cycle 1, mem_enable = mem_wr = 1, mem_addr = 0020, mem_data_in = BEEF, wr_done = 1; state is IDLE in cycle 2.
- Memory model inserts 2-cycle gaps between valids → fill_word still runs 0–7 in order; done follows the 8th valid by exactly one cycle.
- rst_n pulsed low during cycle 6 of an I-fill, then d_req asserted immediately → all outputs are 0 during reset; stale valids are ignored; the D-fill returns exactly 8 correct words.
- mem_data_valid pulsed in IDLE with no request → no fill_we and no done pulses.
